one_wire_master_mc: RTL and testbench
=====================================

Name: one_wire_master_mc

Overview:
- N-channel 1-Wire bus master bit/byte engine, the parametrised successor of the single-channel master inside the 1-Wire PHY top.
- One shared timing engine time-multiplexed across CHANNELS open-drain buses. Commands are issued per channel: reset/presence, single bit slot, or 8-bit LSB-first byte transfer.
- A response carries the read data and presence status back to the host-side controller (UART command decoder).

Parameters:
- CHANNELS, 4, number of independent 1-Wire buses (1..16).
- CLKS_PER_US, 50, clk cycles per microsecond (T below); the bench uses 4.
- CH_W, 2, width of channel index; must satisfy 2**CH_W >= CHANNELS.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- cmd_valid, input, 1, command request.
- cmd_ready, output, 1, engine idle; command accepted when cmd_valid && cmd_ready.
- cmd_op, input, 2, 00 RESET, 01 BIT, 10 BYTE, 11 reserved.
- cmd_chan, input, CH_W, target channel.
- cmd_data, input, 8, write data; BIT uses [0].
- rsp_valid, output, 1, one-cycle response pulse; no backpressure.
- rsp_data, output, 8, read data: BIT in [0] with [7:1]=0; BYTE LSB-first.
- rsp_presence, output, 1, presence detected (RESET only, else 0).
- rsp_err, output, 1, invalid channel or reserved op.
- rsp_chan, output, CH_W, channel of this response.
- ow_in, input, CHANNELS, raw bus levels.
- ow_out, output, CHANNELS, constant 0 (open-drain drive value).
- ow_oe, output, CHANNELS, 1 = pull bus low; at most one bit set at any time.

Behaviour:
- Reset (async, immediate):
  - ow_oe=0 (all buses released mid-slot).
  - cmd_ready=1, rsp_* = 0, state IDLE, counters 0, synchronisers 1.
- Inputs: every ow_in bit passes through a 2-flop synchroniser. All samples use the synchronised value.
- Acceptance:
  - Latches op, chan and data, and clears the cycle counter.
  - cmd_ready falls the next cycle and stays 0 until the cycle after rsp_valid.
  - Cycle count c=0 is the first cycle after acceptance.
- Error path: cmd_chan >= CHANNELS or op=11. No bus activity; rsp_valid at c=0 with rsp_err=1 and rsp_data=0.
- States: IDLE, RST_LOW, RST_WAIT, SLOT_LOW, SLOT_REC, RESP.
- RESET:
  - RST_LOW: ow_oe[chan]=1 for c=0..480T-1.
  - RST_WAIT: released from c=480T; presence = (sync bus==0) sampled at c=550T.
  - Phase ends after c=960T-1. RESP at c=960T: rsp_valid, rsp_presence.
- Bit slot (70T cycles):
  - Low for 6T cycles if the bit is 1, else 60T cycles.
  - Sample sync bus at slot-relative cycle 15T.
  - Release through cycle 70T-1 (SLOT_REC).
  - A 0-bit slot samples 0 (bus self-driven); no mismatch checking.
- BIT: one slot using cmd_data[0]; RESP at c=70T with rsp_data[0]=sample.
- BYTE:
  - 8 back-to-back slots with no gap, bit i = cmd_data[i], sample shifted into rsp_data[i].
  - RESP at c=560T. Reading a byte = writing 0xFF.
- Sampling is exact-cycle; slave glitches outside the sample cycle are ignored.
- rsp_data, rsp_presence, rsp_err and rsp_chan hold their values until the next response; they are meaningful only while rsp_valid=1.
- cmd_valid while busy is ignored (not queued); the host must hold it.
- Non-selected channels: ow_oe=0 at all times, including during RESP and IDLE.
- Counter widths are sized for 960*CLKS_PER_US; no wrap occurs within a command.

Test Plan:
- CLKS_PER_US=4, RESET on ch2, slave model pulls low at c=1960..2199 -> ow_oe[2]=1 for exactly c=0..1919; rsp_valid at c=3840 with rsp_presence=1, rsp_chan=2, rsp_err=0.
- RESET on ch0 with no slave (bus high) -> rsp_presence=0 at c=3840; ow_oe[3:1]=0 throughout.
- BYTE ch1 cmd_data=0xA5, bus passive -> low pulse widths per slot (LSB first) 24,240,24,240,240,24,240,24 cycles; rsp_data=0xA5 at c=2240.
- BYTE ch3 cmd_data=0xFF, slave holds bus low through slot-relative cycles 0..79 in slots 1 and 6 -> rsp_data=0xBD.
- cmd_chan=3 with CHANNELS=3, or op=11 -> rsp_valid at c=0 with rsp_err=1; ow_oe stays 0; cmd_ready back to 1 the next cycle.
- rst_n asserted at c=100 of a ch1 RESET -> ow_oe=0 in the same cycle (async); after release cmd_ready=1 and a new BIT command (data=1) completes normally with rsp_data=0x01.

Source files
------------

// File: rtl/one_wire_master_mc.sv
// one_wire_master_mc: N-channel 1-Wire bus master. One timing engine is shared
// across all buses. It runs reset/presence sequences, single bit slots, and
// 8-bit LSB-first byte transfers on the channel given with each command.
module one_wire_master_mc #(
  parameter int CHANNELS    = 4,
  parameter int CLKS_PER_US = 50,
  parameter int CH_W        = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [CH_W-1:0]     cmd_chan,
  input  logic [7:0]          cmd_data,
  output logic                rsp_valid,
  output logic [7:0]          rsp_data,
  output logic                rsp_presence,
  output logic                rsp_err,
  output logic [CH_W-1:0]     rsp_chan,
  input  logic [CHANNELS-1:0] ow_in,
  output logic [CHANNELS-1:0] ow_out,
  output logic [CHANNELS-1:0] ow_oe
);

  typedef enum logic [1:0] {OP_RESET = 2'b00, OP_BIT = 2'b01, OP_BYTE = 2'b10, OP_RSVD = 2'b11} op_t;
  typedef enum logic [2:0] {ST_IDLE, ST_RST_LOW, ST_RST_WAIT, ST_SLOT_LOW, ST_SLOT_REC, ST_RESP} state_t;

  // One counter serves both the 960 us reset phase and the 70 us slot.
  localparam int CNT_W = $clog2(960 * CLKS_PER_US + 1);
  localparam logic [CNT_W-1:0] C_RST_LOW_END = CNT_W'(480 * CLKS_PER_US - 1);
  localparam logic [CNT_W-1:0] C_PRES_SAMPLE = CNT_W'(550 * CLKS_PER_US);
  localparam logic [CNT_W-1:0] C_RST_END     = CNT_W'(960 * CLKS_PER_US - 1);
  localparam logic [CNT_W-1:0] C_LOW1_END    = CNT_W'(6 * CLKS_PER_US - 1);
  localparam logic [CNT_W-1:0] C_LOW0_END    = CNT_W'(60 * CLKS_PER_US - 1);
  localparam logic [CNT_W-1:0] C_BIT_SAMPLE  = CNT_W'(15 * CLKS_PER_US);
  localparam logic [CNT_W-1:0] C_SLOT_END    = CNT_W'(70 * CLKS_PER_US - 1);

  state_t                r_state;
  op_t                   r_op;
  logic [CH_W-1:0]       r_chan;
  logic [7:0]            r_tx;
  logic [7:0]            r_rx;
  logic [2:0]            r_bit_idx;
  logic [2:0]            r_last_idx;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_pres;
  logic                  r_ready;
  logic [CHANNELS-1:0]   r_oe;
  logic [CHANNELS-1:0]   r_sync1;
  logic [CHANNELS-1:0]   r_sync2;
  logic                  r_rsp_valid;
  logic [7:0]            r_rsp_data;
  logic                  r_rsp_presence;
  logic                  r_rsp_err;
  logic [CH_W-1:0]       r_rsp_chan;

  logic [CHANNELS-1:0]   w_cmd_sel;
  logic [CHANNELS-1:0]   w_sel;
  logic                  w_cmd_ok;
  logic                  w_accept;
  logic                  w_bus;
  logic [CNT_W-1:0]      w_low_end;

  // Channel index to one-hot bus mask; out-of-range indices select nothing.
  function automatic logic [CHANNELS-1:0] chan_onehot(input logic [CH_W-1:0] ch);
    logic [CHANNELS-1:0] v;
    v = '0;
    for (int i = 0; i < CHANNELS; i++) v[i] = (ch == CH_W'(i));
    return v;
  endfunction

  assign w_cmd_sel = chan_onehot(cmd_chan);
  assign w_sel     = chan_onehot(r_chan);
  assign w_cmd_ok  = (w_cmd_sel != '0) && (op_t'(cmd_op) != OP_RSVD);
  assign w_accept  = cmd_valid && r_ready;
  assign w_bus     = |(r_sync2 & w_sel);
  assign w_low_end = r_tx[r_bit_idx] ? C_LOW1_END : C_LOW0_END;

  assign cmd_ready    = r_ready;
  assign ow_out       = '0;
  assign ow_oe        = r_oe;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign rsp_presence = r_rsp_presence;
  assign rsp_err      = r_rsp_err;
  assign rsp_chan     = r_rsp_chan;

  // Bus synchronisers, command sequencing FSM and all registered outputs.
  // NOTE: every register here uses non-blocking assignment so all updates see
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_op           <= OP_RESET;
      r_chan         <= '0;
      r_tx           <= '0;
      r_rx           <= '0;
      r_bit_idx      <= '0;
      r_last_idx     <= '0;
      r_cnt          <= '0;
      r_pres         <= 1'b0;
      r_ready        <= 1'b1;
      r_oe           <= '0;
      r_sync1        <= '1;
      r_sync2        <= '1;
      r_rsp_valid    <= 1'b0;
      r_rsp_data     <= '0;
      r_rsp_presence <= 1'b0;
      r_rsp_err      <= 1'b0;
      r_rsp_chan     <= '0;
    end else begin
      r_sync1 <= ow_in;
      r_sync2 <= r_sync1;

      // The bit sample lands in SLOT_LOW for 0-bits and SLOT_REC for 1-bits.
      if ((r_state == ST_SLOT_LOW || r_state == ST_SLOT_REC) && r_cnt == C_BIT_SAMPLE)
        r_rx[r_bit_idx] <= w_bus;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_ready    <= 1'b0;
            r_op       <= op_t'(cmd_op);
            r_chan     <= cmd_chan;
            r_tx       <= cmd_data;
            r_rx       <= '0;
            r_bit_idx  <= '0;
            r_last_idx <= (op_t'(cmd_op) == OP_BYTE) ? 3'd7 : 3'd0;
            r_cnt      <= '0;
            r_pres     <= 1'b0;
            if (!w_cmd_ok) begin
              r_state        <= ST_RESP;
              r_rsp_valid    <= 1'b1;
              r_rsp_err      <= 1'b1;
              r_rsp_data     <= '0;
              r_rsp_presence <= 1'b0;
              r_rsp_chan     <= cmd_chan;
            end else begin
              r_oe    <= w_cmd_sel;
              r_state <= (op_t'(cmd_op) == OP_RESET) ? ST_RST_LOW : ST_SLOT_LOW;
            end
          end
        end

        ST_RST_LOW: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == C_RST_LOW_END) begin
            r_oe    <= '0;
            r_state <= ST_RST_WAIT;
          end
        end

        ST_RST_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == C_PRES_SAMPLE) r_pres <= ~w_bus;
          if (r_cnt == C_RST_END) begin
            r_state        <= ST_RESP;
            r_rsp_valid    <= 1'b1;
            r_rsp_err      <= 1'b0;
            r_rsp_data     <= '0;
            r_rsp_presence <= r_pres;
            r_rsp_chan     <= r_chan;
          end
        end

        ST_SLOT_LOW: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == w_low_end) begin
            r_oe    <= '0;
            r_state <= ST_SLOT_REC;
          end
        end

        ST_SLOT_REC: begin
          if (r_cnt == C_SLOT_END) begin
            if (r_bit_idx == r_last_idx) begin
              r_state        <= ST_RESP;
              r_rsp_valid    <= 1'b1;
              r_rsp_err      <= 1'b0;
              r_rsp_data     <= r_rx;
              r_rsp_presence <= 1'b0;
              r_rsp_chan     <= r_chan;
            end else begin
              // Next slot starts immediately, with no recovery gap.
              r_cnt     <= '0;
              r_bit_idx <= r_bit_idx + 1'b1;
              r_oe      <= w_sel;
              r_state   <= ST_SLOT_LOW;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_RESP: begin
          r_rsp_valid <= 1'b0;
          r_ready     <= 1'b1;
          r_state     <= ST_IDLE;
        end

        default: begin
          r_oe    <= '0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_one_wire_master_mc.sv
// tb_one_wire_master_mc: randomized and directed commands against a timing-level
// model of 1-Wire transactions, with scoreboards for responses and bus pulses.
module tb_one_wire_master_mc;

  localparam int NCH = 4;
  localparam int T   = 4;
  localparam int CW  = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [1:0]     cmd_op = '0;
  logic [CW-1:0]  cmd_chan = '0;
  logic [7:0]     cmd_data = '0;
  logic           rsp_valid;
  logic [7:0]     rsp_data;
  logic           rsp_presence;
  logic           rsp_err;
  logic [CW-1:0]  rsp_chan;
  logic [NCH-1:0] ow_in;
  logic [NCH-1:0] ow_out;
  logic [NCH-1:0] ow_oe;

  one_wire_master_mc #(.CHANNELS(NCH), .CLKS_PER_US(T), .CH_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_chan(cmd_chan), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_presence(rsp_presence),
    .rsp_err(rsp_err), .rsp_chan(rsp_chan),
    .ow_in(ow_in), .ow_out(ow_out), .ow_oe(ow_oe)
  );

  always #5 clk = ~clk;

  typedef struct { int chan; int err; int pres; int data; int lat; } rsp_t;
  typedef struct { int chan; int start; int width; } pulse_t;

  rsp_t   exp_rsp[$];
  pulse_t exp_pulse[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Cycle index since the latest accepted command (c in the timing rules).
  int tb_c = 0;
  always @(posedge clk) begin
    if (cmd_valid && cmd_ready) tb_c <= 0;
    else tb_c <= tb_c + 1;
  end

  // Slave model for the command in flight.
  int         cur_op = 3;
  int         cur_chan = 0;
  logic [7:0] cur_mask = '0;
  int         cur_present = 0;
  int         cur_lo = 0;
  int         cur_hi = 0;
  logic [NCH-1:0] slave_pull;

  always_comb begin
    int slot;
    int rel;
    int nbits;
    slave_pull = '0;
    slot  = tb_c / (70 * T);
    rel   = tb_c % (70 * T);
    nbits = (cur_op == 2) ? 8 : 1;
    if (cur_chan < NCH) begin
      if (cur_op == 0) begin
        if (cur_present != 0 && tb_c >= cur_lo && tb_c <= cur_hi) slave_pull[cur_chan] = 1'b1;
        if (cur_present == 0 && tb_c >= 2600 && tb_c <= 2620) slave_pull[cur_chan] = 1'b1;
      end else if (cur_op == 1 || cur_op == 2) begin
        if (slot < nbits) begin
          if (cur_mask[slot] && rel < 80) slave_pull[cur_chan] = 1'b1;
          if (!cur_mask[slot] && rel >= 100 && rel <= 120) slave_pull[cur_chan] = 1'b1;
        end
      end
    end
  end

  assign ow_in = ~ow_oe & ~slave_pull;

  // Response monitor.
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && rsp_valid) begin
      if (exp_rsp.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        e = exp_rsp.pop_front();
        check("rsp_chan", int'(rsp_chan), e.chan);
        check("rsp_err", int'(rsp_err), e.err);
        check("rsp_presence", int'(rsp_presence), e.pres);
        check("rsp_data", int'(rsp_data), e.data);
        check("rsp_latency", tb_c, e.lat);
      end
    end
  end

  // Bus drive monitor: legality every cycle, pulse timing per low pulse.
  logic [NCH-1:0] prev_oe = '0;
  int             pulse_start = 0;
  int             pulse_chan = 0;
  always @(negedge clk) begin
    pulse_t e;
    int ch;
    if (!rst_n) begin
      prev_oe <= '0;
    end else begin
      check("bus_legal", int'({ow_out, ($countones(ow_oe) <= 1)}), 1);
      ch = 0;
      for (int i = 0; i < NCH; i++) if (ow_oe[i]) ch = i;
      if (prev_oe == '0 && ow_oe != '0) begin
        pulse_start <= tb_c;
        pulse_chan  <= ch;
      end else if (prev_oe != '0 && ow_oe == '0) begin
        if (exp_pulse.size() == 0) begin
          check("pulse_unexpected", 1, 0);
        end else begin
          e = exp_pulse.pop_front();
          check("pulse_chan", pulse_chan, e.chan);
          check("pulse_start", pulse_start, e.start);
          check("pulse_width", tb_c - pulse_start, e.width);
        end
      end else if (prev_oe != '0 && ow_oe != prev_oe) begin
        check("pulse_chan_switch", int'(ow_oe), int'(prev_oe));
      end
      prev_oe <= ow_oe;
    end
  end

  // Issue one command; the model fills both scoreboards at issue time.
  task automatic send(input int op, input int chan, input logic [7:0] data,
                      input logic [7:0] mask, input int present, input int lo, input int hi);
    rsp_t   r;
    pulse_t p;
    int     n;
    int     wait_cyc = 0;
    @(negedge clk);
    while (!cmd_ready && wait_cyc < 5000) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!cmd_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    cur_op = op; cur_chan = chan; cur_mask = mask;
    cur_present = present; cur_lo = lo; cur_hi = hi;
    r.chan = chan; r.err = 0; r.pres = 0; r.data = 0;
    if (chan >= NCH || op == 3) begin
      r.err = 1;
      r.lat = 0;
    end else if (op == 0) begin
      p.chan = chan; p.start = 0; p.width = 480 * T;
      exp_pulse.push_back(p);
      r.pres = present;
      r.lat  = 960 * T;
    end else begin
      n = (op == 2) ? 8 : 1;
      for (int i = 0; i < n; i++) begin
        p.chan = chan; p.start = i * 70 * T; p.width = data[i] ? 6 * T : 60 * T;
        exp_pulse.push_back(p);
        if (data[i] && !mask[i]) r.data = r.data | (1 << i);
      end
      r.lat = n * 70 * T;
    end
    exp_rsp.push_back(r);
    cmd_op = 2'(op); cmd_chan = CW'(chan); cmd_data = data; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((!cmd_ready || rsp_valid) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", int'(cmd_ready), 1);
  endtask

  initial begin
    #12;
    check("reset_ready", int'(cmd_ready), 1);
    check("reset_rsp_valid", int'(rsp_valid), 0);
    check("reset_oe", int'(ow_oe), 0);
    check("reset_rsp_fields", int'({rsp_data, rsp_presence, rsp_err, rsp_chan}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    send(0, 2, 8'h00, 8'h00, 1, 1960, 2199);
    send(0, 0, 8'h00, 8'h00, 0, 0, 0);
    send(2, 1, 8'hA5, 8'h00, 0, 0, 0);
    send(2, 3, 8'hFF, 8'h42, 0, 0, 0);
    send(1, 5, 8'h01, 8'h00, 0, 0, 0);
    check("err_ready_low", int'(cmd_ready), 0);
    check("err_rsp_now", int'(rsp_valid), 1);
    @(posedge clk); #1;
    check("err_ready_back", int'(cmd_ready), 1);
    send(3, 0, 8'h55, 8'h00, 0, 0, 0);
    send(1, 0, 8'h00, 8'h00, 0, 0, 0);
    send(1, 2, 8'h01, 8'h01, 0, 0, 0);
    send(1, 3, 8'h01, 8'h00, 0, 0, 0);

    // Randomized commands, occasionally on invalid channels.
    for (int k = 0; k < 12; k++) begin
      send(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), 8'($urandom),
           8'($urandom), int'($urandom_range(0, 1)),
           int'($urandom_range(1925, 2150)), int'($urandom_range(2199, 2400)));
    end
    wait_idle();

    // Asynchronous reset in the middle of a reset low phase.
    send(0, 1, 8'h00, 8'h00, 1, 1960, 2199);
    begin
      int n = 0;
      while (tb_c < 100 && n < 500) begin
        @(negedge clk);
        n++;
      end
    end
    check("pre_reset_oe", int'(ow_oe), 2);
    #1 rst_n = 1'b0;
    #1;
    check("async_oe_clear", int'(ow_oe), 0);
    check("async_ready", int'(cmd_ready), 1);
    exp_rsp.delete();
    exp_pulse.delete();
    cur_op = 3;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("post_reset_ready", int'(cmd_ready), 1);
    send(1, 1, 8'h01, 8'h00, 0, 0, 0);
    wait_idle();

    repeat (5) @(negedge clk);
    check("rsp_drain", exp_rsp.size(), 0);
    check("pulse_drain", exp_pulse.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
